// File: rtl/inst_mem_if.sv
// Load and fetch bus of the instruction memory.
// The master side writes program words and issues fetches; the slave side is the memory.
interface inst_mem_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic         LoadEn;
    logic [W-1:0] LoadData;
    logic         LoadLast;
    logic         ReadReq;
    logic [A-1:0] InstAddress;
    logic [W-1:0] InstOut;
    logic         InstValid;
    logic         ProgReady;
    logic [A:0]   LoadCount;
    logic         Overflow;

    modport master (
        output LoadEn, LoadData, LoadLast, ReadReq, InstAddress,
        input  InstOut, InstValid, ProgReady, LoadCount, Overflow
    );

    modport slave (
        input  LoadEn, LoadData, LoadLast, ReadReq, InstAddress,
        output InstOut, InstValid, ProgReady, LoadCount, Overflow
    );
endinterface

// File: rtl/inst_mem.sv
// Instruction memory that is filled word by word with a program, then serves
// single-cycle fetches. Words past the loaded program read back as zero.
module inst_mem #(
    parameter int A = 10,
    parameter int W = 9
) (
    input logic Clk,
    input logic Reset,
    inst_mem_if.slave bus
);
    localparam int DEPTH = 2 ** A;
    localparam logic [A:0] FULL = {1'b1, {A{1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t       state;
    logic [W-1:0] mem [DEPTH];
    logic [A:0]   load_count;
    logic         overflow;
    logic         prog_ready;
    logic [W-1:0] inst_out;
    logic         inst_valid;
    logic         mem_we;
    logic [A-1:0] mem_waddr;

    // A load outside LOADING always restarts the program at word 0.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        if (!Reset && bus.LoadEn) begin
            if (state != LOADING) begin
                mem_we = 1'b1;
            end else if (load_count != FULL) begin
                mem_we    = 1'b1;
                mem_waddr = load_count[A-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= bus.LoadData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= EMPTY;
            load_count <= '0;
            overflow   <= 1'b0;
            prog_ready <= 1'b0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (bus.LoadEn) begin
                if (state != LOADING) begin
                    load_count <= {{A{1'b0}}, 1'b1};
                    overflow   <= 1'b0;
                    state      <= bus.LoadLast ? READY : LOADING;
                    prog_ready <= bus.LoadLast;
                end else begin
                    if (load_count == FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        load_count <= load_count + 1'b1;
                    end
                    if (bus.LoadLast) begin
                        state      <= READY;
                        prog_ready <= 1'b1;
                    end
                end
            end else if (bus.ReadReq && state == READY) begin
                // Stale words left over from an earlier, longer program are masked.
                inst_out   <= ({1'b0, bus.InstAddress} < load_count) ? mem[bus.InstAddress] : '0;
                inst_valid <= 1'b1;
            end
        end
    end

    assign bus.InstOut   = inst_out;
    assign bus.InstValid = inst_valid;
    assign bus.ProgReady = prog_ready;
    assign bus.LoadCount = load_count;
    assign bus.Overflow  = overflow;
endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: a default-size and a 4-word instance are
// compared every cycle against a program-level reference model.
module tb_inst_mem;
    logic Clk = 1'b0;
    logic Reset;
    int   tests = 0;
    int   fails = 0;

    always #5 Clk = ~Clk;

    inst_mem_if #(.A(10), .W(9)) bus0 ();
    inst_mem_if #(.A(2),  .W(9)) bus1 ();

    inst_mem #(.A(10), .W(9)) dut       (.Clk(Clk), .Reset(Reset), .bus(bus0));
    inst_mem #(.A(2),  .W(9)) dut_small (.Clk(Clk), .Reset(Reset), .bus(bus1));

    // Reference model: the program is a list of words plus a phase.
    // Phase 0 = empty, 1 = loading, 2 = ready.
    int         depth [2] = '{1024, 4};
    int         phase [2];
    int         cnt   [2];
    bit         ovf   [2];
    logic [8:0] prog  [2][1024];
    logic [8:0] exp_out [2];
    bit         exp_valid [2];

    task automatic modelStep(int id, bit rst, bit en, logic [8:0] data, bit last, bit rd, int addr);
        for (int k = 0; k < 2; k++) begin
            bit ke;
            bit kr;
            ke = (k == id) && en;
            kr = (k == id) && rd;
            if (rst) begin
                phase[k] = 0; cnt[k] = 0; ovf[k] = 0; exp_out[k] = '0; exp_valid[k] = 0;
            end else begin
                exp_valid[k] = 0;
                if (ke) begin
                    if (phase[k] != 1) begin
                        prog[k][0] = data; cnt[k] = 1; ovf[k] = 0;
                        phase[k] = last ? 2 : 1;
                    end else begin
                        if (cnt[k] == depth[k]) ovf[k] = 1;
                        else begin prog[k][cnt[k]] = data; cnt[k]++; end
                        if (last) phase[k] = 2;
                    end
                end else if (kr && phase[k] == 2) begin
                    exp_out[k]   = (addr < cnt[k]) ? prog[k][addr] : 9'h000;
                    exp_valid[k] = 1;
                end
            end
        end
    endtask

    task automatic checkOne(string tag, string what, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        checkOne({tag, "/d0"}, "InstValid", 32'(bus0.InstValid), 32'(exp_valid[0]));
        checkOne({tag, "/d0"}, "InstOut",   32'(bus0.InstOut),   32'(exp_out[0]));
        checkOne({tag, "/d0"}, "ProgReady", 32'(bus0.ProgReady), 32'(phase[0] == 2));
        checkOne({tag, "/d0"}, "LoadCount", 32'(bus0.LoadCount), 32'(cnt[0]));
        checkOne({tag, "/d0"}, "Overflow",  32'(bus0.Overflow),  32'(ovf[0]));
        checkOne({tag, "/d1"}, "InstValid", 32'(bus1.InstValid), 32'(exp_valid[1]));
        checkOne({tag, "/d1"}, "InstOut",   32'(bus1.InstOut),   32'(exp_out[1]));
        checkOne({tag, "/d1"}, "ProgReady", 32'(bus1.ProgReady), 32'(phase[1] == 2));
        checkOne({tag, "/d1"}, "LoadCount", 32'(bus1.LoadCount), 32'(cnt[1]));
        checkOne({tag, "/d1"}, "Overflow",  32'(bus1.Overflow),  32'(ovf[1]));
    endtask

    // Drives one cycle on instance 'id' (the other idles), then checks both.
    task automatic applyStimulus(string tag, int id, bit rst, bit en, logic [8:0] data,
                                 bit last, bit rd, int addr);
        Reset = rst;
        bus0.LoadEn = (id == 0) && en;  bus0.LoadData = data;  bus0.LoadLast = last;
        bus0.ReadReq = (id == 0) && rd; bus0.InstAddress = 10'(addr);
        bus1.LoadEn = (id == 1) && en;  bus1.LoadData = data;  bus1.LoadLast = last;
        bus1.ReadReq = (id == 1) && rd; bus1.InstAddress = 2'(addr);
        @(posedge Clk);
        modelStep(id, rst, en, data, last, rd, addr);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        applyStimulus("reset", 0, 1, 0, 9'h000, 0, 0, 0);
        applyStimulus("idle_empty", 0, 0, 0, 9'h000, 0, 1, 0);

        applyStimulus("load_w0", 0, 0, 1, 9'h011, 0, 0, 0);
        applyStimulus("load_w1", 0, 0, 1, 9'h022, 0, 0, 0);
        applyStimulus("load_w2_last", 0, 0, 1, 9'h1FF, 1, 0, 0);
        applyStimulus("fetch_a2", 0, 0, 0, 9'h000, 0, 1, 2);
        applyStimulus("hold", 0, 0, 0, 9'h000, 1, 0, 0);
        applyStimulus("fetch_a5_zero", 0, 0, 0, 9'h000, 0, 1, 5);

        applyStimulus("b2b_a0", 0, 0, 0, 9'h000, 0, 1, 0);
        applyStimulus("b2b_a1", 0, 0, 0, 9'h000, 0, 1, 1);
        applyStimulus("b2b_a2", 0, 0, 0, 9'h000, 0, 1, 2);

        applyStimulus("restart_prio", 0, 0, 1, 9'h0AA, 0, 1, 0);
        applyStimulus("rd_in_loading", 0, 0, 0, 9'h000, 0, 1, 0);
        applyStimulus("finish_load", 0, 0, 1, 9'h0BB, 1, 0, 0);
        applyStimulus("fetch_stale_masked", 0, 0, 0, 9'h000, 0, 1, 2);

        applyStimulus("ov_w1", 1, 0, 1, 9'h101, 0, 0, 0);
        applyStimulus("ov_w2", 1, 0, 1, 9'h102, 0, 0, 0);
        applyStimulus("ov_w3", 1, 0, 1, 9'h103, 0, 0, 0);
        applyStimulus("ov_w4", 1, 0, 1, 9'h104, 0, 0, 0);
        applyStimulus("ov_w5_last", 1, 0, 1, 9'h105, 1, 0, 0);
        applyStimulus("ov_fetch_a3", 1, 0, 0, 9'h000, 0, 1, 3);

        applyStimulus("mid_w0", 0, 0, 1, 9'h033, 0, 0, 0);
        applyStimulus("mid_w1", 0, 0, 1, 9'h044, 0, 0, 0);
        applyStimulus("mid_reset_with_load", 0, 1, 1, 9'h055, 1, 1, 0);
        applyStimulus("rej_after_reset", 0, 0, 0, 9'h000, 0, 1, 0);
        applyStimulus("reload_w0", 0, 0, 1, 9'h066, 0, 0, 0);
        applyStimulus("rej_while_loading", 0, 0, 0, 9'h000, 0, 1, 0);
        applyStimulus("reload_last", 0, 0, 1, 9'h077, 1, 0, 0);
        applyStimulus("reload_fetch_a1", 0, 0, 0, 9'h000, 0, 1, 1);
        applyStimulus("last_without_en", 0, 0, 0, 9'h000, 1, 1, 0);

        for (int i = 0; i < 600; i++) begin
            int   id;
            logic [8:0] data;
            id   = int'($urandom_range(0, 1));
            data = 9'($urandom);
            applyStimulus("random", id, ($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                          data, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
                          (id == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 11)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
